// File: rtl/hss_pkg.sv
// hss_pkg: types and helpers shared across the filter output path.
//   DATA_W   - sample width used by the capture FIFO and the energy block
//   sample_t - signed sample type
//   sat_abs  - absolute value that saturates the most-negative code
package hss_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  // |x|, with -2^(DATA_W-1) mapped to 2^(DATA_W-1)-1 because its true
  // magnitude cannot be represented in DATA_W bits.
  function automatic sample_t sat_abs(input sample_t x);
    sample_t most_neg;
    sample_t most_pos;
    most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    most_pos = {1'b0, {(DATA_W-1){1'b1}}};
    if (x == most_neg) return most_pos;
    else if (x[DATA_W-1]) return -x;
    else return x;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: DEPTH x DATA_W simple dual-port RAM.
//   CLK, RST          - clock, async active-low reset (read register only)
//   wr_en/addr/data   - synchronous write port
//   rd_en/addr        - read strobe and address
//   rd_data           - registered read data, 1-cycle latency, holds when rd_en=0
// A read and a write to the same address on one edge returns the old contents.
module capture_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/filt_capture_fifo.sv
// filt_capture_fifo: decimating capture FIFO for the low-pass filter output.
//   CLK, RST            - clock, async active-low reset
//   enable              - capture enable; low clears the decimation phase
//   in_data, in_valid   - filtered sample stream
//   rd_req              - pop one entry per asserted cycle
//   clr_ovf             - clear sticky overflow
//   rd_data, rd_valid   - popped entry, valid one cycle after the pop
//   count, empty, full  - registered occupancy
//   overflow            - sticky: a kept sample was dropped on a full FIFO
// Build option: define CAPTURE_ABS_EN to store saturated |in_data|
// instead of the raw sample.
module filt_capture_fifo
  import hss_pkg::*;
#(
  parameter int DATA_W = hss_pkg::DATA_W,
  parameter int DEPTH  = 64,
  parameter int DECIM  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              rd_req,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           empty_q, empty_d;
  logic           full_q, full_d;
  logic [DCW-1:0] decim_cnt_q, decim_cnt_d;
  logic           rd_valid_q, rd_valid_d;
  logic           ovf_q, ovf_d;

  logic              kept, push, pop, drop;
  logic [DATA_W-1:0] wr_data;

`ifdef CAPTURE_ABS_EN
  assign wr_data = DATA_W'(sat_abs(sample_t'(in_data)));
`else
  assign wr_data = in_data;
`endif

  always_comb begin
    kept = enable & in_valid & (decim_cnt_q == '0);
    pop  = rd_req & ~empty_q;
    // A pop on a full FIFO frees the slot the push needs this same edge.
    push = kept & (~full_q | pop);
    drop = kept & full_q & ~pop;

    decim_cnt_d = decim_cnt_q;
    if (!enable) decim_cnt_d = '0;
    else if (in_valid) begin
      if (decim_cnt_q == DCW'(DECIM - 1)) decim_cnt_d = '0;
      else                                decim_cnt_d = decim_cnt_q + DCW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);

    empty_d    = (count_d == '0);
    full_d     = (count_d == (AW+1)'(DEPTH));
    rd_valid_d = pop;
    // A drop on the same edge as a clear wins so no loss goes unreported.
    ovf_d      = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      decim_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      decim_cnt_q <= decim_cnt_d;
      rd_valid_q  <= rd_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_filt_capture_fifo.sv
module tb_filt_capture_fifo;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enable;
  logic [15:0] in_data;
  logic        in_valid;
  logic        rd_req;
  logic        clr_ovf;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [6:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  filt_capture_fifo #(.DATA_W(16), .DEPTH(64), .DECIM(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .rd_req   (rd_req),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
    in_valid = 1'b0;
  endtask

  // With DECIM=2 and phase 0: first sample kept, filler discarded.
  task automatic push_kept(input logic [15:0] v);
    send(v);
    send(16'hDEAD);
  endtask

  task automatic test_reset();
    n_tests++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_tests++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
  endtask

  task automatic test_decimation();
    int nv;
    logic [15:0] got [2];
    got[0] = '0; got[1] = '0;
    send(16'h0968); send(16'h0F38); send(16'h0F38); send(16'h0968);
    n_tests++; if (count !== 7'd2) begin n_fail++; $display("FAIL decim_count: got %0d want 2", count); end
    nv = 0;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rd_valid === 1'b1) begin
        if (nv < 2) got[nv] = rd_data;
        nv++;
      end
    end
    rd_req = 1'b0;
    n_tests++; if (nv != 2) begin n_fail++; $display("FAIL decim_nvalid: got %0d want 2", nv); end
    n_tests++; if (got[0] !== 16'h0968) begin n_fail++; $display("FAIL decim_data0: got %h want 0968", got[0]); end
    n_tests++; if (got[1] !== 16'h0F38) begin n_fail++; $display("FAIL decim_data1: got %h want 0f38", got[1]); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL decim_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 64; i++) push_kept(16'h0100 + 16'(i));
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_tests++; if (count !== 7'd64) begin n_fail++; $display("FAIL fill_count: got %0d want 64", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pre: got %b want 0", overflow); end
    push_kept(16'hBEEF);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_set: got %b want 1", overflow); end
    n_tests++; if (count !== 7'd64) begin n_fail++; $display("FAIL fill_count_drop: got %0d want 64", count); end
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_clr: got %b want 0", overflow); end
    // drop and clear on the same edge: overflow must end up set
    in_valid = 1'b1; in_data = 16'hBEEF; clr_ovf = 1'b1;
    cyc();
    in_valid = 1'b0; clr_ovf = 1'b0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_vs_clr: got %b want 1", overflow); end
    send(16'hDEAD);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp;
    in_valid = 1'b1; in_data = 16'h1234; rd_req = 1'b1;
    cyc();
    in_valid = 1'b0; rd_req = 1'b0;
    n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_rd_valid: got %b want 1", rd_valid); end
    n_tests++; if (rd_data !== 16'h0100) begin n_fail++; $display("FAIL fpp_rd_data: got %h want 0100", rd_data); end
    n_tests++; if (count !== 7'd64) begin n_fail++; $display("FAIL fpp_count: got %0d want 64", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
    send(16'hDEAD);
    rd_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc();
      exp = (i < 63) ? 16'h0101 + 16'(i) : 16'h1234;
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
      end
    end
    cyc();
    rd_req = 1'b0;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_rd: got %b want 0", rd_valid); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_empty_read();
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL er_rd_valid: got %b want 0", rd_valid); end
    n_tests++; if (rd_data !== 16'h1234) begin n_fail++; $display("FAIL er_hold: got %h want 1234", rd_data); end
    in_valid = 1'b1; in_data = 16'h4321; rd_req = 1'b1;
    cyc();
    in_valid = 1'b0; rd_req = 1'b0;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL er_push_rd_valid: got %b want 0", rd_valid); end
    n_tests++; if (count !== 7'd1) begin n_fail++; $display("FAIL er_push_count: got %0d want 1", count); end
    send(16'hDEAD);
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== 16'h4321) begin
      n_fail++; $display("FAIL er_pop: got v=%b d=%h want v=1 d=4321", rd_valid, rd_data);
    end
  endtask

  task automatic test_enable();
    send(16'h0AAA);
    enable = 1'b0;
    send(16'h0BBB);
    n_tests++; if (count !== 7'd1) begin n_fail++; $display("FAIL en_ignore: got %0d want 1", count); end
    enable = 1'b1;
    send(16'h0CCC);
    n_tests++; if (count !== 7'd2) begin n_fail++; $display("FAIL en_phase_clr: got %0d want 2", count); end
    send(16'hDEAD);
    rd_req = 1'b1; cyc();
    n_tests++; if (rd_data !== 16'h0AAA) begin n_fail++; $display("FAIL en_data0: got %h want 0aaa", rd_data); end
    cyc(); rd_req = 1'b0;
    n_tests++; if (rd_data !== 16'h0CCC) begin n_fail++; $display("FAIL en_data1: got %h want 0ccc", rd_data); end
  endtask

  task automatic test_abs();
    logic [15:0] vin  [3];
    logic [15:0] vexp [3];
    vin[0] = 16'hF000; vin[1] = 16'h8000; vin[2] = 16'h0010;
`ifdef CAPTURE_ABS_EN
    vexp[0] = 16'h1000; vexp[1] = 16'h7FFF; vexp[2] = 16'h0010;
`else
    vexp[0] = 16'hF000; vexp[1] = 16'h8000; vexp[2] = 16'h0010;
`endif
    for (int i = 0; i < 3; i++) push_kept(vin[i]);
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== vexp[i]) begin
        n_fail++; $display("FAIL abs[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, vexp[i]);
      end
    end
    rd_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_kept(16'h0200 + 16'(i));
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    n_tests++; if (rd_valid !== 1'b1 || count !== 7'd4) begin
      n_fail++; $display("FAIL rm_pre: got v=%b count=%0d want v=1 count=4", rd_valid, count);
    end
    #2;
    RST = 1'b0;
    #1;
    n_tests++; if (count !== 7'd0) begin n_fail++; $display("FAIL rm_count: got %0d want 0", count); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rm_empty: got %b want 1", empty); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rd_valid: got %b want 0", rd_valid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_ovf: got %b want 0", overflow); end
    n_tests++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rm_rd_data: got %h want 0000", rd_data); end
    #3;
    RST = 1'b1;
    cyc();
    n_tests++; if (count !== 7'd0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_post: got count=%0d v=%b want 0 0", count, rd_valid);
    end
  endtask

  initial begin
    RST = 1'b0; enable = 1'b0; in_data = '0; in_valid = 1'b0; rd_req = 1'b0; clr_ovf = 1'b0;
    #12;
    test_reset();
    #3;
    RST = 1'b1;
    enable = 1'b1;
    cyc();
    test_decimation();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_read();
    test_enable();
    test_abs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
